// File: rtl/common_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and the NOP word
// that pipeline registers load on a bubble or flush.
package common;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazard_state_type;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;

endpackage

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// reg_scoreboard: pending-write bit per architectural register with two
// combinational lookup ports. A clear on the same register in the same cycle
// masks the lookup, since the writeback value is on the bypass path.
module reg_scoreboard
  import common::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        set_en,
  input  logic [REG_W-1:0]            set_idx,
  input  logic                        clr_en,
  input  logic [REG_W-1:0]            clr_idx,
  input  logic [1:0][REG_W-1:0]       rd_idx,
  output logic [1:0]                  rd_pend,
  output logic [NUM_REGS-1:0]         bits
);

  // x0 is never written, so it can never be pending
  assign bits[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    // set wins over clear so a new producer on the released register sticks
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        bits[r] <= 1'b0;
      else if (set_en && set_idx == REG_W'(r))
        bits[r] <= 1'b1;
      else if (clr_en && clr_idx == REG_W'(r))
        bits[r] <= 1'b0;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign rd_pend[p] = bits[rd_idx[p]] & ~(clr_en && clr_idx == rd_idx[p]);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard detection and IF/ID, ID/EX sequencing for
// the 5-stage core. Load-use, mul/div scoreboard and mispredict recovery.
// Optional stall watchdog is built when HAZARD_WATCHDOG_EN is defined.
module hazard_ctrl
  import common::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int WD_LIMIT     = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_muldiv,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              md_done,
  input  logic [4:0]        md_rd,
  input  logic              mispredict,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              md_busy,
  output logic [31:0]       scoreboard,
  output logic              wd_error
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 2);

  hazard_state_type   state, state_nxt;
  logic [CNT_W-1:0]   fcnt, fcnt_nxt;
  logic               lu, sb, mdq, hazard, issue, md_issue;
  logic [1:0]         pend;

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .set_en  (md_issue && id_rd != 5'd0),
    .set_idx (id_rd),
    .clr_en  (md_done),
    .clr_idx (md_rd),
    .rd_idx  ({id_rs2, id_rs1}),
    .rd_pend (pend),
    .bits    (scoreboard)
  );

  // hazard terms; a mul/div writeback this cycle frees both the register and
  // the unit, so dependent or queued work proceeds in the done cycle
  always_comb begin
    lu = id_valid && ex_mem_read && ex_rd != 5'd0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    sb = id_valid && ((id_use_rs1 && pend[0]) || (id_use_rs2 && pend[1]));
    mdq = id_valid && id_muldiv && md_busy && !md_done;
    hazard = lu || sb || mdq;
  end

  // pipeline controls; mispredict outranks hazards, FLUSH suppresses stalls
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (reset_n) begin
      if (mispredict || state == FLUSH) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hazard) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
    issue    = id_valid && !pc_stall && !if_id_flush && reset_n;
    md_issue = issue && id_muldiv;
  end

  // FSM next state; the flush counter holds the remaining FLUSH cycles
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (mispredict) begin
      state_nxt = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
      fcnt_nxt  = CNT_W'(FLUSH_CYCLES);
    end else begin
      case (state)
        RUN:   if (hazard) state_nxt = STALL;
        STALL: if (!hazard) state_nxt = RUN;
        FLUSH: begin
          if (fcnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt - CNT_W'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // state and flush counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // one outstanding mul/div; survives mispredicts since it predates the branch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      md_busy <= 1'b0;
    else if (md_issue)
      md_busy <= 1'b1;
    else if (md_done)
      md_busy <= 1'b0;
  end

`ifdef HAZARD_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;

  // counts consecutive stall cycles, saturating; error is sticky to reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt   <= '0;
      wd_error <= 1'b0;
    end else if (pc_stall) begin
      if (wd_cnt != WD_W'(WD_LIMIT))
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_W'(WD_LIMIT - 1))
        wd_error <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_error = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=1, WD_LIMIT=4).
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_muldiv;
  logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, md_rd;
  logic        ex_mem_read, md_done, mispredict;
  logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, md_busy, wd_error;
  logic [31:0] scoreboard;
  logic [3:0]  outs;
  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.FLUSH_CYCLES(1), .WD_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_muldiv(id_muldiv), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .md_done(md_done), .md_rd(md_rd),
    .mispredict(mispredict), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .md_busy(md_busy),
    .scoreboard(scoreboard), .wd_error(wd_error)
  );

  always #5 clk = ~clk;
  assign outs = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush};

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_muldiv = 0; ex_rd = 0; ex_mem_read = 0;
    md_done = 0; md_rd = 0; mispredict = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic md);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = rd; id_muldiv = md;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset_n = 0;
    #3;
    n_cmp++; if (outs !== 4'b0000) begin n_bad++; $display("FAIL reset_outs got %b want 0000", outs); end
    n_cmp++; if (scoreboard !== 32'h0 || md_busy !== 1'b0 || wd_error !== 1'b0) begin
      n_bad++; $display("FAIL reset_state got sb=%h busy=%b wd=%b want 0/0/0", scoreboard, md_busy, wd_error); end
    tick(); reset_n = 1; tick();
  endtask

  task automatic test_load_use();
    ex_rd = 5; ex_mem_read = 1; dec(5, 1, 6, 0); #1;
    n_cmp++; if (outs !== 4'b1110) begin n_bad++; $display("FAIL lu_stall got %b want 1110", outs); end
    tick(); ex_rd = 0; ex_mem_read = 0; #1;
    n_cmp++; if (outs !== 4'b0000) begin n_bad++; $display("FAIL lu_release got %b want 0000", outs); end
    tick(); ex_rd = 0; ex_mem_read = 1; dec(0, 0, 0, 0); #1;
    n_cmp++; if (outs !== 4'b0000) begin n_bad++; $display("FAIL lu_x0 got %b want 0000", outs); end
    tick(); idle();
  endtask

  task automatic test_muldiv_dep();
    dec(1, 2, 7, 1); #1;
    n_cmp++; if (outs !== 4'b0000) begin n_bad++; $display("FAIL mul_issue got %b want 0000", outs); end
    tick(); dec(7, 7, 8, 0); #1;
    n_cmp++; if (scoreboard !== 32'h0000_0080 || md_busy !== 1'b1) begin
      n_bad++; $display("FAIL mul_sb got sb=%h busy=%b want 00000080/1", scoreboard, md_busy); end
    n_cmp++; if (outs !== 4'b1110) begin n_bad++; $display("FAIL dep_stall got %b want 1110", outs); end
    tick();
    n_cmp++; if (outs !== 4'b1110 || wd_error !== 1'b0) begin
      n_bad++; $display("FAIL dep_hold got %b wd=%b want 1110 wd=0", outs, wd_error); end
    md_done = 1; md_rd = 7; #1;
    n_cmp++; if (outs !== 4'b0000) begin n_bad++; $display("FAIL dep_release got %b want 0000", outs); end
    tick(); idle(); #1;
    n_cmp++; if (scoreboard !== 32'h0 || md_busy !== 1'b0) begin
      n_bad++; $display("FAIL dep_clear got sb=%h busy=%b want 0/0", scoreboard, md_busy); end
  endtask

  task automatic test_md_busy();
    dec(1, 2, 9, 1); tick(); dec(1, 2, 10, 1); #1;
    n_cmp++; if (outs !== 4'b1110) begin n_bad++; $display("FAIL mdq_stall got %b want 1110", outs); end
    tick(); md_done = 1; md_rd = 9; #1;
    n_cmp++; if (outs !== 4'b0000) begin n_bad++; $display("FAIL mdq_release got %b want 0000", outs); end
    tick(); idle(); #1;
    n_cmp++; if (scoreboard !== 32'h0000_0400 || md_busy !== 1'b1) begin
      n_bad++; $display("FAIL mdq_handoff got sb=%h busy=%b want 00000400/1", scoreboard, md_busy); end
    md_done = 1; md_rd = 10; tick(); idle(); #1;
    n_cmp++; if (scoreboard !== 32'h0 || md_busy !== 1'b0) begin
      n_bad++; $display("FAIL mdq_drain got sb=%h busy=%b want 0/0", scoreboard, md_busy); end
  endtask

  task automatic test_mispredict();
    ex_rd = 5; ex_mem_read = 1; dec(5, 1, 6, 0); tick();
    mispredict = 1; #1;
    n_cmp++; if (outs !== 4'b0011) begin n_bad++; $display("FAIL mp_cycle0 got %b want 0011", outs); end
    tick(); mispredict = 0; #1;
    n_cmp++; if (outs !== 4'b0011) begin n_bad++; $display("FAIL mp_cycle1 got %b want 0011", outs); end
    tick(); idle(); #1;
    n_cmp++; if (outs !== 4'b0000) begin n_bad++; $display("FAIL mp_done got %b want 0000", outs); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    dec(1, 2, 7, 1); tick(); dec(7, 3, 8, 0); #1;
    n_cmp++; if (outs !== 4'b1110 || scoreboard !== 32'h0000_0080) begin
      n_bad++; $display("FAIL rst_pre got %b sb=%h want 1110 sb=00000080", outs, scoreboard); end
    #1 reset_n = 0; #1;
    n_cmp++; if (outs !== 4'b0000 || scoreboard !== 32'h0 || md_busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_async got %b sb=%h busy=%b want 0000/0/0", outs, scoreboard, md_busy); end
    idle(); tick(); reset_n = 1; tick();
  endtask

`ifdef HAZARD_WATCHDOG_EN
  task automatic test_watchdog();
    dec(1, 2, 7, 1); tick(); dec(7, 7, 8, 0);
    tick(); tick(); tick();
    n_cmp++; if (wd_error !== 1'b0) begin n_bad++; $display("FAIL wd_early got %b want 0", wd_error); end
    tick();
    n_cmp++; if (wd_error !== 1'b1) begin n_bad++; $display("FAIL wd_trip got %b want 1", wd_error); end
    md_done = 1; md_rd = 7; tick(); idle(); tick();
    n_cmp++; if (wd_error !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got %b want 1", wd_error); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_muldiv_dep();
    test_md_busy();
    test_mispredict();
    test_reset_mid_stall();
`ifdef HAZARD_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
